// File: rtl/nvdla_done_intr_gen_pkg.sv
// -----------------------------------------------------------------------------
// nvdla_done_intr_gen_pkg
// Shared definitions for the done-interrupt generator and the units that talk
// to it: the layer-sequencing FSM state encoding, the width of the
// done-interrupt payload sent to the global interrupt controller, and a helper
// that turns a register-group index into a one-hot group mask.
// -----------------------------------------------------------------------------
package nvdla_done_intr_gen_pkg;

  // One bit per register group in the done-interrupt payload.
  localparam int INTR_PD_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fsm_state_e;

  function automatic logic [INTR_PD_W-1:0] group_onehot(input logic grp);
    logic [INTR_PD_W-1:0] mask;
    mask      = '0;
    mask[grp] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/nvdla_ostd_cnt.sv
// -----------------------------------------------------------------------------
// nvdla_ostd_cnt
// Saturating counter of outstanding DMA write requests.
//   clk    in   clock
//   srst   in   synchronous active-high reset
//   inc    in   one request accepted (pulse)
//   dec    in   one response returned (pulse)
//   count  out  current number of outstanding writes (register)
//   full   out  count is at its maximum value (decoded from the register)
//   err    out  sticky: a response arrived with nothing outstanding
// A simultaneous inc and dec cancel, even at the boundaries, so neither the
// saturation nor the underflow error can be triggered by that combination.
// -----------------------------------------------------------------------------
module nvdla_ostd_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         err
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;
  logic         err_reg;
  logic         err_next;

  always_comb begin
    count_next = count_reg;
    err_next   = err_reg;
    if (inc && !dec) begin
      // Saturate instead of wrapping when already full.
      if (count_reg != CNT_MAX) begin
        count_next = count_reg + CNT_ONE;
      end
    end else if (dec && !inc) begin
      if (count_reg != '0) begin
        count_next = count_reg - CNT_ONE;
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  assign count = count_reg;
  assign full  = (count_reg == CNT_MAX);
  assign err   = err_reg;

endmodule

// File: rtl/nvdla_done_intr_gen.sv
// -----------------------------------------------------------------------------
// nvdla_done_intr_gen
// Sequences layers across two ping-pong register groups and raises the
// per-group done interrupt once the datapath has finished a layer and every
// DMA write of that layer has been acknowledged.
//   nvdla_core_clk      in   clock
//   nvdla_core_rst      in   synchronous active-high reset
//   reg2dp_op_en_g0/g1  in   register group armed (levels)
//   dp2intr_layer_end   in   datapath issued its last write (pulse)
//   dma_wr_req_acc      in   DMA write request accepted (pulse)
//   dma_wr_rsp          in   DMA write response returned (pulse)
//   intr2dp_op_load     out  start the layer using group intr2dp_consumer
//   intr2dp_consumer    out  index of the active register group
//   intr2reg_op_en_clr  out  one-hot clear of the finished group's op_en
//   intr2dma_wr_allow   out  outstanding-write counter not full
//   x2glb_done_intr_pd  out  done interrupt, bit g = group g finished
//   intr_ostd_err       out  sticky write-response underflow
//   intr_busy           out  a layer is in flight
// -----------------------------------------------------------------------------
module nvdla_done_intr_gen
  import nvdla_done_intr_gen_pkg::*;
#(
  parameter int OSTD_W = 8
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic                 reg2dp_op_en_g0,
  input  logic                 reg2dp_op_en_g1,
  input  logic                 dp2intr_layer_end,
  input  logic                 dma_wr_req_acc,
  input  logic                 dma_wr_rsp,
  output logic                 intr2dp_op_load,
  output logic                 intr2dp_consumer,
  output logic [1:0]           intr2reg_op_en_clr,
  output logic                 intr2dma_wr_allow,
  output logic [INTR_PD_W-1:0] x2glb_done_intr_pd,
  output logic                 intr_ostd_err,
  output logic                 intr_busy
);

  fsm_state_e           state_reg;
  logic                 consumer_reg;
  logic                 op_load_reg;
  logic [1:0]           op_en_clr_reg;
  logic [INTR_PD_W-1:0] done_pd_reg;

  logic [OSTD_W-1:0]    ostd_count;
  logic                 ostd_full;
  logic [1:0]           op_en;

  assign op_en = {reg2dp_op_en_g1, reg2dp_op_en_g0};

  // The counter tracks writes in every state, independent of the FSM.
  nvdla_ostd_cnt #(
    .W (OSTD_W)
  ) u_ostd_cnt (
    .clk   (nvdla_core_clk),
    .srst  (nvdla_core_rst),
    .inc   (dma_wr_req_acc),
    .dec   (dma_wr_rsp),
    .count (ostd_count),
    .full  (ostd_full),
    .err   (intr_ostd_err)
  );

  // Pulse outputs are set on the transition into the state they belong to so
  // that they are high for exactly the one cycle spent in LOAD or DONE.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_reg     <= ST_IDLE;
      consumer_reg  <= 1'b0;
      op_load_reg   <= 1'b0;
      op_en_clr_reg <= '0;
      done_pd_reg   <= '0;
    end else begin
      op_load_reg   <= 1'b0;
      op_en_clr_reg <= '0;
      done_pd_reg   <= '0;
      case (state_reg)
        ST_IDLE: begin
          // Only the group whose turn it is can start a layer.
          if (op_en[consumer_reg]) begin
            state_reg   <= ST_LOAD;
            op_load_reg <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_reg <= ST_BUSY;
        end
        ST_BUSY: begin
          if (dp2intr_layer_end) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Wait for every outstanding write of the layer to be acknowledged.
          if (ostd_count == '0) begin
            state_reg     <= ST_DONE;
            done_pd_reg   <= group_onehot(consumer_reg);
            op_en_clr_reg <= group_onehot(consumer_reg);
          end
        end
        ST_DONE: begin
          state_reg    <= ST_IDLE;
          consumer_reg <= ~consumer_reg;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign intr2dp_op_load    = op_load_reg;
  assign intr2dp_consumer   = consumer_reg;
  assign intr2reg_op_en_clr = op_en_clr_reg;
  assign x2glb_done_intr_pd = done_pd_reg;
  assign intr2dma_wr_allow  = ~ostd_full;
  assign intr_busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_nvdla_done_intr_gen.sv
// -----------------------------------------------------------------------------
// tb_nvdla_done_intr_gen
// Directed bench for nvdla_done_intr_gen. A main instance (OSTD_W=8) runs the
// layer-sequencing scenarios; a second instance (OSTD_W=2) exercises counter
// saturation. A behavioural model tracks the expected outputs of both and is
// compared every cycle; literal expectations pin key cycles of each scenario.
// -----------------------------------------------------------------------------
module tb_nvdla_done_intr_gen;

  localparam int MAX8 = 255;
  localparam int MAX2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic op_en_g0 = 1'b0;
  logic op_en_g1 = 1'b0;
  logic layer_end = 1'b0;
  logic acc = 1'b0;
  logic rsp = 1'b0;

  logic       op_load;
  logic       consumer;
  logic [1:0] op_en_clr;
  logic       wr_allow;
  logic [1:0] pd;
  logic       ostd_err;
  logic       busy;

  // Second instance: only the counter is driven.
  logic       acc2 = 1'b0;
  logic       rsp2 = 1'b0;
  logic       tie0 = 1'b0;
  logic       op_load_2;
  logic       consumer_2;
  logic [1:0] op_en_clr_2;
  logic       wr_allow_2;
  logic [1:0] pd_2;
  logic       ostd_err_2;
  logic       busy_2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nvdla_done_intr_gen #(.OSTD_W(8)) u_dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rst     (rst),
    .reg2dp_op_en_g0    (op_en_g0),
    .reg2dp_op_en_g1    (op_en_g1),
    .dp2intr_layer_end  (layer_end),
    .dma_wr_req_acc     (acc),
    .dma_wr_rsp         (rsp),
    .intr2dp_op_load    (op_load),
    .intr2dp_consumer   (consumer),
    .intr2reg_op_en_clr (op_en_clr),
    .intr2dma_wr_allow  (wr_allow),
    .x2glb_done_intr_pd (pd),
    .intr_ostd_err      (ostd_err),
    .intr_busy          (busy)
  );

  nvdla_done_intr_gen #(.OSTD_W(2)) u_dut2 (
    .nvdla_core_clk     (clk),
    .nvdla_core_rst     (rst),
    .reg2dp_op_en_g0    (tie0),
    .reg2dp_op_en_g1    (tie0),
    .dp2intr_layer_end  (tie0),
    .dma_wr_req_acc     (acc2),
    .dma_wr_rsp         (rsp2),
    .intr2dp_op_load    (op_load_2),
    .intr2dp_consumer   (consumer_2),
    .intr2reg_op_en_clr (op_en_clr_2),
    .intr2dma_wr_allow  (wr_allow_2),
    .x2glb_done_intr_pd (pd_2),
    .intr_ostd_err      (ostd_err_2),
    .intr_busy          (busy_2)
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // A layer is "active" from the load pulse until the done pulse has been
  // given; within it the layer is first loading, then running until the
  // datapath reports its end, then waiting for the write count to reach zero.
  bit m_valid  = 1'b0;
  bit m_cons   = 1'b0;
  bit m_active = 1'b0;
  bit m_load   = 1'b0;
  bit m_ended  = 1'b0;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;
  bit m_err2   = 1'b0;
  int m_cnt    = 0;
  int m_cnt2   = 0;

  function automatic int next_count(input int c, input bit a, input bit r, input int mx);
    if (a && !r) return (c < mx) ? c + 1 : c;
    if (r && !a) return (c > 0) ? c - 1 : 0;
    return c;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_valid  = 1'b1;
      m_cons   = 1'b0;
      m_active = 1'b0;
      m_load   = 1'b0;
      m_ended  = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_err2   = 1'b0;
      m_cnt    = 0;
      m_cnt2   = 0;
    end else begin
      if (m_done) begin
        m_done   = 1'b0;
        m_active = 1'b0;
        m_ended  = 1'b0;
        m_cons   = !m_cons;
      end else if (!m_active) begin
        if (m_cons ? op_en_g1 : op_en_g0) begin
          m_active = 1'b1;
          m_load   = 1'b1;
        end
      end else if (m_load) begin
        m_load = 1'b0;
      end else if (!m_ended) begin
        if (layer_end) m_ended = 1'b1;
      end else if (m_cnt == 0) begin
        m_done = 1'b1;
      end
      if (rsp && !acc && m_cnt == 0) m_err = 1'b1;
      if (rsp2 && !acc2 && m_cnt2 == 0) m_err2 = 1'b1;
      m_cnt  = next_count(m_cnt, acc, rsp, MAX8);
      m_cnt2 = next_count(m_cnt2, acc2, rsp2, MAX2);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("op_load", int'(op_load), int'(m_load));
      chk("consumer", int'(consumer), int'(m_cons));
      chk("busy", int'(busy), int'(m_active));
      chk("done_pd", int'(pd), m_done ? (m_cons ? 2 : 1) : 0);
      chk("op_en_clr", int'(op_en_clr), m_done ? (m_cons ? 2 : 1) : 0);
      chk("wr_allow", int'(wr_allow), int'(m_cnt != MAX8));
      chk("ostd_err", int'(ostd_err), int'(m_err));
      chk("wr_allow2", int'(wr_allow_2), int'(m_cnt2 != MAX2));
      chk("ostd_err2", int'(ostd_err_2), int'(m_err2));
      chk("quiet2", int'({op_load_2, consumer_2, op_en_clr_2, pd_2, busy_2}), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    op_en_g0  = 1'b0;
    op_en_g1  = 1'b0;
    layer_end = 1'b0;
    acc       = 1'b0;
    rsp       = 1'b0;
    acc2      = 1'b0;
    rsp2      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_busy", int'(busy), 0);
    chk("rst_consumer", int'(consumer), 0);
    chk("rst_pd", int'(pd), 0);
    chk("rst_clr", int'(op_en_clr), 0);
    chk("rst_load", int'(op_load), 0);
    chk("rst_wr_allow", int'(wr_allow), 1);
    chk("rst_err", int'(ostd_err), 0);

    // Scenario 1: single layer on group 0 with three writes; op_en dropped mid-layer.
    for (int t = 0; t <= 17; t++) begin
      op_en_g0  = (t < 5);
      acc       = (t >= 2 && t <= 4);
      layer_end = (t == 10);
      rsp       = (t >= 12 && t <= 14);
      tick();
      if (t == 0) chk("s1_load", int'(op_load), 1);
      if (t == 1) chk("s1_load_one_cycle", int'(op_load), 0);
      if (t == 14) chk("s1_pd_before", int'(pd), 0);
      if (t == 15) begin
        chk("s1_pd", int'(pd), 1);
        chk("s1_clr", int'(op_en_clr), 1);
      end
      if (t == 16) begin
        chk("s1_consumer", int'(consumer), 1);
        chk("s1_pd_after", int'(pd), 0);
      end
      if (t == 17) chk("s1_idle", int'(busy), 0);
    end

    // Scenario 2: both groups armed, no writes, layer_end two cycles after each load.
    do_reset();
    for (int t = 0; t <= 15; t++) begin
      op_en_g0  = (t < 13);
      op_en_g1  = (t < 13);
      layer_end = (t == 2 || t == 7 || t == 12);
      tick();
      if (t == 3) chk("s2_pd_first", int'(pd), 1);
      if (t == 8) chk("s2_pd_second", int'(pd), 2);
      if (t == 13) chk("s2_pd_third", int'(pd), 1);
      if (t == 4 || t == 9) chk("s2_idle_gap", int'(busy), 0);
      if (t == 5 || t == 10) chk("s2_reload", int'(op_load), 1);
    end

    // Scenario 3: OSTD_W=2 instance saturates at 3.
    do_reset();
    for (int t = 0; t <= 6; t++) begin
      acc2 = (t <= 4);
      rsp2 = (t == 4 || t == 5);
      tick();
      if (t == 1) chk("s3_allow_cnt2", int'(wr_allow_2), 1);
      if (t == 2) chk("s3_full", int'(wr_allow_2), 0);
      if (t == 3) chk("s3_saturate", int'(wr_allow_2), 0);
      if (t == 4) chk("s3_acc_rsp_full", int'(wr_allow_2), 0);
      if (t == 5) chk("s3_rsp_allow", int'(wr_allow_2), 1);
      if (t == 6) chk("s3_no_err", int'(ostd_err_2), 0);
    end

    // Scenario 4: underflow error is sticky across a full layer, cleared by reset.
    do_reset();
    for (int t = 0; t <= 8; t++) begin
      op_en_g0  = (t == 0);
      rsp       = (t == 0);
      layer_end = (t == 4);
      tick();
      if (t == 0) chk("s4_err_set", int'(ostd_err), 1);
      if (t == 5) chk("s4_pd", int'(pd), 1);
      if (t == 8) chk("s4_err_sticky", int'(ostd_err), 1);
    end
    do_reset();
    chk("s4_err_cleared", int'(ostd_err), 0);

    // Scenario 5: reset in DRAIN with five writes outstanding.
    for (int t = 0; t <= 7; t++) begin
      op_en_g0  = (t == 0);
      acc       = (t >= 1 && t <= 5);
      layer_end = (t == 3);
      tick();
      chk("s5_no_pd", int'(pd), 0);
      if (t == 7) chk("s5_in_drain", int'(busy), 1);
    end
    rst = 1'b1;
    acc = 1'b1;
    tick();
    rst = 1'b0;
    acc = 1'b0;
    chk("s5_rst_busy", int'(busy), 0);
    chk("s5_rst_consumer", int'(consumer), 0);
    chk("s5_rst_allow", int'(wr_allow), 1);
    chk("s5_rst_pd", int'(pd), 0);
    // A lone response now must underflow, proving the count restarted at zero.
    rsp = 1'b1;
    tick();
    rsp = 1'b0;
    chk("s5_count_zero", int'(ostd_err), 1);

    // Scenario 6: only group 1 armed while consumer is 0.
    do_reset();
    op_en_g1 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("s6_idle", int'(busy), 0);
      chk("s6_no_load", int'(op_load), 0);
    end
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nvdla_done_intr_gen.md
NVDLA_DONE_INTR_GEN -- requirements
Module: nvdla_done_intr_gen

Interface
REQ-001 SHALL have parameter OSTD_W, default 8, width of the outstanding-DMA-write counter (legal 2..16).
REQ-002 SHALL have ports, in order:
- nvdla_core_clk  in  1  sole clock.
- nvdla_core_rst  in  1  reset; one clock, synchronous, active-high.
- reg2dp_op_en_g0  in  1  level; register group 0 armed.
- reg2dp_op_en_g1  in  1  level; register group 1 armed.
- dp2intr_layer_end  in  1  pulse; datapath has issued the last write of the current layer.
- dma_wr_req_acc  in  1  pulse; one DMA write request accepted.
- dma_wr_rsp  in  1  pulse; one DMA write response returned.
- intr2dp_op_load  out  1  pulse; start layer using group intr2dp_consumer.
- intr2dp_consumer  out  1  index of the active register group.
- intr2reg_op_en_clr  out  2  one-hot pulse; clears op_en of the finished group.
- intr2dma_wr_allow  out  1  high when the counter is not full.
- x2glb_done_intr_pd  out  2  done-interrupt pd to the global interrupt controller; bit g = group g done.
- intr_ostd_err  out  1  sticky; response received with counter at zero.
- intr_busy  out  1  high in any state except IDLE.

Function
REQ-003 SHALL implement the FSM IDLE -> LOAD -> BUSY -> DRAIN -> DONE -> IDLE.
REQ-004 In IDLE, SHALL go to LOAD on the cycle after op_en of group consumer is sampled high; the other group's op_en SHALL be ignored.
REQ-005 In LOAD, SHALL assert intr2dp_op_load for exactly 1 cycle, then go to BUSY.
REQ-006 In BUSY, SHALL go to DRAIN when dp2intr_layer_end is sampled high; layer_end in any other state SHALL be ignored.
REQ-007 In DRAIN, SHALL go to DONE on the first cycle the counter equals 0, including the cycle DRAIN is entered.
REQ-008 In DONE (1 cycle):
- assert x2glb_done_intr_pd[consumer] and intr2reg_op_en_clr[consumer];
- toggle consumer at the clock edge;
- go to IDLE.
REQ-009 Minimum latency is 1 cycle from layer_end sampled to the done pulse, when the counter is already 0.
REQ-010 Counter update per cycle: acc only -> +1; rsp only (count>0) -> -1; acc and rsp together -> unchanged, including at zero and at full.
REQ-011 Counter update runs in every FSM state.
REQ-012 intr2dma_wr_allow SHALL equal (count != 2^OSTD_W-1), combinational from the count register.
REQ-013 acc while full SHALL leave the count saturated; no wrap.
REQ-014 rsp alone with count 0 SHALL leave the count at 0 and set intr_ostd_err; the error clears only on reset.
REQ-015 At most one bit of x2glb_done_intr_pd SHALL be high in any cycle; both bits are pulses, never levels.
REQ-016 Back-to-back: with both groups armed, groups SHALL alternate 0,1,0,... with exactly 1 IDLE cycle between DONE and the next LOAD.
REQ-017 If op_en of the active group drops during BUSY or DRAIN, the layer SHALL still complete and the done pulse SHALL still fire.

Reset
REQ-018 On reset SHALL set: state IDLE, consumer 0, count 0, intr_ostd_err 0.
REQ-019 Reset values of outputs: op_load 0, op_en_clr 0, done_intr_pd 0, busy 0, wr_allow 1.
REQ-020 Reset asserted mid-layer SHALL abort without any done pulse; pulse inputs in the reset cycle SHALL be ignored.

Structure
REQ-021 A shared package SHALL hold the FSM state enum (3-bit encoding) and the 2-bit intr-pd width constant; GLB and the datapath units import the same package.
REQ-022 The counter SHALL be one sub-module, nvdla_ostd_cnt (inc, dec, count, full, err), instantiated once.
REQ-023 All outputs SHALL be registered except intr2dma_wr_allow, intr2dp_consumer and intr_busy, which decode registers directly.

Verification
REQ-024 Required directed scenarios:
- op_en_g0=1 at cycle 0, 3 acc, layer_end at cycle 10, 3 rsp at cycles 12-14 -> pd=2'b01 at cycle 15; op_en_clr=2'b01; consumer becomes 1.
- Both groups armed, zero writes, layer_end 2 cycles after each load -> pd sequence 01,10,01 with 1 IDLE cycle between DONE and the next LOAD.
- OSTD_W=2, 3 acc, then acc+rsp in the same cycle -> count stays 3, wr_allow=0; one further rsp -> wr_allow=1.
- rsp with count 0 -> intr_ostd_err=1 and stays 1 through a full layer; cleared by reset.
- Reset asserted in DRAIN with count 5 -> no pd pulse; next cycle state IDLE, count 0, consumer 0.
- Only op_en_g1 armed while consumer=0 -> stays IDLE with busy=0 indefinitely.
